counter_32bit: RTL and testbench

General-purpose 32-bit synchronous up/down counter with clear, parallel load, terminal-count flag and rollover pulse. It serves as the reference counting primitive in the simulation flow and can be instantiated wherever a free-running or gated event/cycle counter is needed. All state changes occur on the rising clock edge. The only exception is the asynchronous reset.

---
 rtl/counter_32bit_pkg.sv | 17 +
 rtl/counter_32bit_if.sv | 25 ++
 rtl/counter_32bit_next.sv | 45 ++++
 rtl/counter_32bit.sv | 46 ++++
 tb/tb_counter_32bit.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/counter_32bit_pkg.sv
// Shared types and constants for the 32-bit up/down counter.
// Compile-time only: no latency, no backpressure.
package counter_32bit_pkg;

  localparam int CNT_W = 32;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX         = 32'hFFFF_FFFF;
  localparam cnt_t RESET_VALUE_DEF = 32'h0000_0000;

  // Terminal count: the next step in the current direction would roll over.
  function automatic logic is_terminal(input cnt_t cnt, input logic up_dn);
    return up_dn ? (cnt == CNT_MAX) : (cnt == '0);
  endfunction

endpackage

// File: rtl/counter_32bit_if.sv
// Control and status bundle of counter_32bit; slave is the counter, master the user.
// No latency of its own; no backpressure (inputs are sampled every cycle).
interface counter_32bit_if;
  import counter_32bit_pkg::*;

  logic en;
  logic clr;
  logic load;
  cnt_t load_val;
  logic up_dn;
  cnt_t cnt_out;
  logic tc;
  logic wrap;

  modport master (
    output en, clr, load, load_val, up_dn,
    input  cnt_out, tc, wrap
  );

  modport slave (
    input  en, clr, load, load_val, up_dn,
    output cnt_out, tc, wrap
  );

endinterface

// File: rtl/counter_32bit_next.sv
// Next-state logic: clr > load > en > hold; saturates instead of wrapping when COUNTER_32BIT_SAT_EN is defined.
// Purely combinational (zero latency); no backpressure.
module counter_32bit_next
  import counter_32bit_pkg::*;
(
  input  cnt_t cnt,
  input  logic up_dn,
  input  logic en,
  input  logic clr,
  input  logic load,
  input  cnt_t load_val,
  output cnt_t cnt_nxt,
  output logic tc,
  output logic rollover
);

  cnt_t step;
  logic step_rolls;

  always_comb begin
    tc         = is_terminal(cnt, up_dn);
    step       = up_dn ? (cnt + cnt_t'(1)) : (cnt - cnt_t'(1));
`ifdef COUNTER_32BIT_SAT_EN
    // Stepping past the boundary is suppressed, so nothing ever rolls over.
    if (tc) begin
      step = cnt;
    end
    step_rolls = 1'b0;
`else
    step_rolls = tc;
`endif

    cnt_nxt  = cnt;
    rollover = 1'b0;
    if (clr) begin
      cnt_nxt = '0;
    end else if (load) begin
      cnt_nxt = load_val;
    end else if (en) begin
      cnt_nxt  = step;
      rollover = step_rolls;
    end
  end

endmodule

// File: rtl/counter_32bit.sv
// 32-bit up/down counter with clear, load, tc and wrap pulse; COUNTER_32BIT_SAT_EN selects saturation.
// cnt_out/wrap update one edge after inputs, tc is combinational; never stalls the user.
module counter_32bit
  import counter_32bit_pkg::*;
#(
  parameter int   WIDTH       = CNT_W,
  parameter cnt_t RESET_VALUE = RESET_VALUE_DEF
) (
  input  logic            clk,
  input  logic            n_reset,
  counter_32bit_if.slave  bus
);

  logic [WIDTH-1:0] cnt_q;
  logic             wrap_q;
  cnt_t             cnt_nxt;
  logic             tc;
  logic             rollover;

  counter_32bit_next u_next (
    .cnt      (cnt_q),
    .up_dn    (bus.up_dn),
    .en       (bus.en),
    .clr      (bus.clr),
    .load     (bus.load),
    .load_val (bus.load_val),
    .cnt_nxt  (cnt_nxt),
    .tc       (tc),
    .rollover (rollover)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_q  <= RESET_VALUE;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_nxt;
      wrap_q <= rollover;
    end
  end

  assign bus.cnt_out = cnt_q;
  assign bus.wrap    = wrap_q;
  assign bus.tc      = tc;

endmodule

// File: tb/tb_counter_32bit.sv
// Directed bench for counter_32bit: expected outputs are queued as stimulus is driven and checked after each edge.
module tb_counter_32bit;
  import counter_32bit_pkg::*;

  typedef struct {
    cnt_t  cnt;
    logic  wrap;
    logic  tc;
    string tag;
  } exp_t;

  logic clk;
  logic n_reset;
  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  counter_32bit_if bus ();

  counter_32bit #(
    .WIDTH       (32),
    .RESET_VALUE (32'h0000_0000)
  ) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: run did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  task automatic expect_out(input cnt_t c, input logic w, input logic t, input string tag);
    exp_t e;
    e.cnt = c; e.wrap = w; e.tc = t; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty got=%0d required=1", exp_q.size());
      return;
    end
    e = exp_q.pop_front();
    checks++;
    assert (bus.cnt_out === e.cnt) else begin
      failures++;
      $error("FAIL %s cnt_out got=%h required=%h", e.tag, bus.cnt_out, e.cnt);
    end
    checks++;
    assert (bus.wrap === e.wrap) else begin
      failures++;
      $error("FAIL %s wrap got=%b required=%b", e.tag, bus.wrap, e.wrap);
    end
    checks++;
    assert (bus.tc === e.tc) else begin
      failures++;
      $error("FAIL %s tc got=%b required=%b", e.tag, bus.tc, e.tc);
    end
  endtask

  // Drive one cycle of inputs, then check the registered result just after the edge.
  task automatic step(input logic e, input logic c, input logic l, input cnt_t lv, input logic ud,
                      input cnt_t ec, input logic ew, input logic etc, input string tag);
    bus.en = e; bus.clr = c; bus.load = l; bus.load_val = lv; bus.up_dn = ud;
    expect_out(ec, ew, etc, tag);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  // Check without waiting for an edge (reset and combinational tc).
  task automatic check_now(input cnt_t ec, input logic ew, input logic etc, input string tag);
    expect_out(ec, ew, etc, tag);
    #1;
    compare_out();
  endtask

  initial begin
    n_reset      = 1'b0;
    bus.en       = 1'b0;
    bus.clr      = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.up_dn    = 1'b1;
    check_now(32'h0, 1'b0, 1'b0, "reset");
    repeat (2) @(posedge clk);
    #1;
    check_now(32'h0, 1'b0, 1'b0, "reset_clocked");
    @(negedge clk);
    n_reset = 1'b1;

    for (int i = 0; i < 1000; i++) step(0, 0, 0, 32'h0, 1, 32'h0, 0, 0, "idle");

    for (int i = 1; i <= 5; i++) step(1, 0, 0, 32'h0, 1, cnt_t'(i), 0, 0, "up_count");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 1, 32'h5, 0, 0, "up_hold");

    step(0, 0, 1, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFE, 0, 0, "load_fffe");
    step(1, 0, 0, 32'h0, 1, 32'hFFFF_FFFF, 0, 1, "up_to_max");
`ifdef COUNTER_32BIT_SAT_EN
    step(1, 0, 0, 32'h0, 1, 32'hFFFF_FFFF, 0, 1, "up_sat");
    step(0, 0, 0, 32'h0, 1, 32'hFFFF_FFFF, 0, 1, "up_sat_hold");
`else
    step(1, 0, 0, 32'h0, 1, 32'h0, 1, 0, "up_wrap");
    step(0, 0, 0, 32'h0, 1, 32'h0, 0, 0, "up_wrap_end");
`endif

    // tc is zero-latency and ignores en/clr/load.
    step(0, 0, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 1, "load_max");
    bus.up_dn = 1'b0;
    check_now(32'hFFFF_FFFF, 0, 0, "tc_dir_change");
    bus.up_dn = 1'b1;
    bus.clr   = 1'b1;
    bus.load  = 1'b1;
    check_now(32'hFFFF_FFFF, 0, 1, "tc_ignores_ctl");

    step(0, 0, 1, 32'h1, 0, 32'h1, 0, 0, "load_one");
    step(1, 0, 0, 32'h0, 0, 32'h0, 0, 1, "down_to_zero");
`ifdef COUNTER_32BIT_SAT_EN
    step(1, 0, 0, 32'h0, 0, 32'h0, 0, 1, "down_sat");
    step(1, 0, 0, 32'h0, 1, 32'h1, 0, 0, "toggle_up");
    step(1, 0, 0, 32'h0, 0, 32'h0, 0, 1, "toggle_down");
`else
    step(1, 0, 0, 32'h0, 0, 32'hFFFF_FFFF, 1, 0, "down_wrap");
    step(1, 0, 0, 32'h0, 1, 32'h0, 1, 0, "toggle_up_wrap");
    step(1, 0, 0, 32'h0, 0, 32'hFFFF_FFFF, 1, 0, "toggle_down_wrap");
`endif
    step(0, 0, 0, 32'h0, 1, (`ifdef COUNTER_32BIT_SAT_EN 32'h0 `else 32'hFFFF_FFFF `endif),
         0, (`ifdef COUNTER_32BIT_SAT_EN 1'b0 `else 1'b1 `endif), "wrap_one_cycle");

    step(1, 1, 1, 32'h1234, 1, 32'h0, 0, 0, "prio_clr");
    step(1, 0, 1, 32'h1234, 1, 32'h1234, 0, 0, "prio_load");
    step(0, 0, 0, 32'h0, 1, 32'h1234, 0, 0, "prio_hold");
    step(0, 1, 0, 32'h0, 0, 32'h0, 0, 1, "clr_only");

    step(0, 0, 1, 32'hC, 1, 32'hC, 0, 0, "load_c");
    for (int i = 13; i <= 16; i++) step(1, 0, 0, 32'h0, 1, cnt_t'(i), 0, 0, "count_to_10");
    #3;
    n_reset = 1'b0;
    check_now(32'h0, 0, 0, "async_reset");
    @(negedge clk);
    n_reset = 1'b1;
    step(1, 0, 0, 32'h0, 1, 32'h1, 0, 0, "post_reset_step");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
